// File: rtl/instruction_queue_if.sv
// -----------------------------------------------------------------------------
// instruction_queue_if
//   Bundles the instruction queue's handshake and bus signals.
//   Signal names carry the i_/o_ prefix as seen from the queue itself.
//   Modports:
//     slave  - the queue: takes pop/imem data and drives fetch/head/status.
//     master - the environment: issue stage plus instruction memory.
//   Signals:
//     i_pop        issue stage consumes the head entry this cycle
//     o_imem_ren   instruction memory read request
//     o_imem_addr  read address (current PC)
//     i_imem_data  read data, valid one cycle after o_imem_ren
//     o_instr      head instruction
//     o_instr_pc   PC of the head instruction
//     o_valid      head entry valid
//     o_full       queue holds DEPTH entries
//     o_count      number of occupied entries
//     o_done       program fully fetched and drained
//     i_flush      redirect request   (only with IQ_FLUSH_EN)
//     i_flush_pc   redirect target PC (only with IQ_FLUSH_EN)
// -----------------------------------------------------------------------------
interface instruction_queue_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              i_pop;
   logic              o_imem_ren;
   logic [ADDR_W-1:0] o_imem_addr;
   logic [DATA_W-1:0] i_imem_data;
   logic [DATA_W-1:0] o_instr;
   logic [ADDR_W-1:0] o_instr_pc;
   logic              o_valid;
   logic              o_full;
   logic [CW-1:0]     o_count;
   logic              o_done;
`ifdef IQ_FLUSH_EN
   logic              i_flush;
   logic [ADDR_W-1:0] i_flush_pc;
`endif

   modport slave (
`ifdef IQ_FLUSH_EN
      input  i_flush, i_flush_pc,
`endif
      input  i_pop, i_imem_data,
      output o_imem_ren, o_imem_addr, o_instr, o_instr_pc,
             o_valid, o_full, o_count, o_done
   );

   modport master (
`ifdef IQ_FLUSH_EN
      output i_flush, i_flush_pc,
`endif
      output i_pop, i_imem_data,
      input  o_imem_ren, o_imem_addr, o_instr, o_instr_pc,
             o_valid, o_full, o_count, o_done
   );
endinterface

// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
//   Fetch/issue front end for the tomasulo issue stage. Walks a PC over the
//   instruction memory, fetches one instruction per cycle into an in-order
//   FIFO and lets the issue stage drain it with pop. Fetch is credit-limited
//   so the FIFO never overflows; o_done flags a fully drained program.
//   Ports:
//     i_clk   clock, rising edge
//     i_rst   synchronous, active-high reset
//     bus     instruction_queue_if.slave (pop, imem request/data, head, status)
//   Parameters: DATA_W, ADDR_W, DEPTH (power of 2, >=2), PROG_LEN.
//   Optional feature: define IQ_FLUSH_EN to add i_flush/i_flush_pc redirect.
// -----------------------------------------------------------------------------
module instruction_queue #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 4,
   parameter int PROG_LEN = 16
) (
   input logic               i_clk,
   input logic               i_rst,
   instruction_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0]     DEPTH_V = (CW+1)'(DEPTH);
   localparam logic [ADDR_W:0] PLEN_V  = (ADDR_W+1)'(PROG_LEN);

   // PC is one bit wider so PROG_LEN == 2**ADDR_W is reachable.
   logic [ADDR_W:0]   r_pc;
   logic              r_inflight;
   logic [ADDR_W-1:0] r_tag_pc;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [ADDR_W-1:0] r_pcs  [DEPTH];

   logic              w_flush;
   logic [ADDR_W-1:0] w_flush_pc;
   logic [CW:0]       w_credit;
   logic              w_req;
   logic              w_wr;
   logic              w_pop;

`ifdef IQ_FLUSH_EN
   assign w_flush    = bus.i_flush;
   assign w_flush_pc = bus.i_flush_pc;
`else
   assign w_flush    = 1'b0;
   assign w_flush_pc = '0;
`endif

   // Credit counts the outstanding response but not a same-cycle pop.
   assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_req    = !i_rst && !w_flush && (r_pc < PLEN_V) && (w_credit < DEPTH_V);
   assign w_wr     = r_inflight;
   assign w_pop    = bus.i_pop && (r_count != '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc       <= '0;
         r_inflight <= 1'b0;
         r_tag_pc   <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
            r_pcs[i]  <= '0;
         end
      end else if (w_flush) begin
         // Dropping r_inflight discards the response arriving next cycle.
         r_pc       <= {1'b0, w_flush_pc};
         r_inflight <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_req;
         if (w_req) begin
            r_pc     <= r_pc + (ADDR_W+1)'(1);
            r_tag_pc <= r_pc[ADDR_W-1:0];
         end
         if (w_wr) begin
            r_data[r_wr_ptr] <= bus.i_imem_data;
            r_pcs[r_wr_ptr]  <= r_tag_pc;
            r_wr_ptr         <= r_wr_ptr + PW'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.o_imem_ren  = w_req;
   assign bus.o_imem_addr = r_pc[ADDR_W-1:0];
   assign bus.o_instr     = r_data[r_rd_ptr];
   assign bus.o_instr_pc  = r_pcs[r_rd_ptr];
   assign bus.o_valid     = (r_count != '0);
   assign bus.o_full      = (r_count == DEPTH_V[CW-1:0]);
   assign bus.o_count     = r_count;
   assign bus.o_done      = !i_rst && (r_pc == PLEN_V) && !r_inflight && (r_count == '0);

endmodule

// File: tb/tb_instruction_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_queue
//   Directed bench for instruction_queue. Instance A runs PROG_LEN=16,
//   instance B runs PROG_LEN=5. Each has a one-cycle-latency instruction
//   memory model returning 0x100 + address.
// -----------------------------------------------------------------------------
module tb_instruction_queue;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int D  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   instruction_queue_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) bus_a ();
   instruction_queue_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) bus_b ();

   instruction_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .PROG_LEN(16)) dut_a (
      .i_clk (clk),
      .i_rst (rst_a),
      .bus   (bus_a)
   );

   instruction_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .PROG_LEN(5)) dut_b (
      .i_clk (clk),
      .i_rst (rst_b),
      .bus   (bus_b)
   );

   always @(posedge clk) begin
      if (bus_a.o_imem_ren) bus_a.i_imem_data <= 16'h0100 + {8'h00, bus_a.o_imem_addr};
      if (bus_b.o_imem_ren) bus_b.i_imem_data <= 16'h0100 + {8'h00, bus_b.o_imem_addr};
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      int n;
      int nren;
      int first_ren;
      int last_ren;
      int maxc;
      int last_pc;

      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.i_pop = 1'b0;
      bus_b.i_pop = 1'b0;
`ifdef IQ_FLUSH_EN
      bus_a.i_flush    = 1'b0;
      bus_a.i_flush_pc = '0;
      bus_b.i_flush    = 1'b0;
      bus_b.i_flush_pc = '0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_ren",   32'(bus_a.o_imem_ren), 0);
      chk("rst_valid", 32'(bus_a.o_valid), 0);
      chk("rst_full",  32'(bus_a.o_full), 0);
      chk("rst_done",  32'(bus_a.o_done), 0);
      chk("rst_count", 32'(bus_a.o_count), 0);
      chk("rst_instr", 32'(bus_a.o_instr), 0);
      chk("rst_ipc",   32'(bus_a.o_instr_pc), 0);

      // 1: fill without popping
      rst_a = 1'b0;
      #1;
      nren = 0; first_ren = -1; last_ren = -1;
      for (int c = 0; c < 8; c++) begin
         if (bus_a.o_imem_ren) begin
            if (first_ren < 0) first_ren = c;
            last_ren = c;
            nren++;
         end
         @(negedge clk);
         #1;
      end
      chk("fill_nren",  32'(nren), 4);
      chk("fill_first", 32'(first_ren), 0);
      chk("fill_last",  32'(last_ren), 3);
      chk("fill_count", 32'(bus_a.o_count), 4);
      chk("fill_full",  32'(bus_a.o_full), 1);
      chk("fill_ren",   32'(bus_a.o_imem_ren), 0);
      chk("fill_valid", 32'(bus_a.o_valid), 1);
      chk("fill_instr", 32'(bus_a.o_instr), 32'h100);
      chk("fill_ipc",   32'(bus_a.o_instr_pc), 0);

      // 2: drain from full with pop held
      bus_a.i_pop = 1'b1;
      #1;
      n = 0; maxc = 0;
      for (int c = 0; c < 60 && n < 16; c++) begin
         if (int'(bus_a.o_count) > maxc) maxc = int'(bus_a.o_count);
         if (bus_a.o_valid) begin
            chk("drain_instr", 32'(bus_a.o_instr), 32'h100 + 32'(n));
            chk("drain_ipc",   32'(bus_a.o_instr_pc), 32'(n));
            n++;
         end
         @(negedge clk);
         #1;
      end
      chk("drain_n",     32'(n), 16);
      chk("drain_maxc",  32'(maxc <= 4), 1);
      chk("drain_done",  32'(bus_a.o_done), 1);
      chk("drain_valid", 32'(bus_a.o_valid), 0);
      chk("drain_ren",   32'(bus_a.o_imem_ren), 0);
      @(negedge clk);
      #1;
      chk("drain_uflow", 32'(bus_a.o_count), 0);
      chk("drain_done2", 32'(bus_a.o_done), 1);

      // 4: pop while empty right after reset
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      #1;
      chk("epop_c0_count", 32'(bus_a.o_count), 0);
      @(negedge clk);
      #1;
      chk("epop_c1_count", 32'(bus_a.o_count), 0);
      chk("epop_c1_valid", 32'(bus_a.o_valid), 0);
      @(negedge clk);
      #1;
      chk("epop_valid", 32'(bus_a.o_valid), 1);
      chk("epop_instr", 32'(bus_a.o_instr), 32'h100);
      chk("epop_ipc",   32'(bus_a.o_instr_pc), 0);
      chk("epop_count", 32'(bus_a.o_count), 1);
      bus_a.i_pop = 1'b0;

      // 5: reset one cycle after a request, Count=2
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("mrst_pre_count", 32'(bus_a.o_count), 2);
      chk("mrst_pre_ren",   32'(bus_a.o_imem_ren), 1);
      rst_a = 1'b1;
      #1;
      chk("mrst_ren_in_rst", 32'(bus_a.o_imem_ren), 0);
      @(negedge clk);
      rst_a = 1'b0;
      #1;
      chk("mrst_count", 32'(bus_a.o_count), 0);
      chk("mrst_valid", 32'(bus_a.o_valid), 0);
      chk("mrst_ren",   32'(bus_a.o_imem_ren), 1);
      chk("mrst_addr",  32'(bus_a.o_imem_addr), 0);
      @(negedge clk);
      #1;
      chk("mrst_stale", 32'(bus_a.o_count), 0);
      @(negedge clk);
      #1;
      chk("mrst_rf_valid", 32'(bus_a.o_valid), 1);
      chk("mrst_rf_instr", 32'(bus_a.o_instr), 32'h100);
      chk("mrst_rf_ipc",   32'(bus_a.o_instr_pc), 0);

`ifdef IQ_FLUSH_EN
      // 6: flush with Count=3 redirects to PC 8
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("fl_pre_count", 32'(bus_a.o_count), 3);
      bus_a.i_flush    = 1'b1;
      bus_a.i_flush_pc = 8'd8;
      #1;
      chk("fl_ren_during", 32'(bus_a.o_imem_ren), 0);
      @(negedge clk);
      bus_a.i_flush = 1'b0;
      #1;
      chk("fl_count", 32'(bus_a.o_count), 0);
      chk("fl_valid", 32'(bus_a.o_valid), 0);
      chk("fl_addr",  32'(bus_a.o_imem_addr), 8);
      n = 0;
      for (int c = 0; c < 10 && !bus_a.o_valid; c++) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("fl_first_valid", 32'(bus_a.o_valid), 1);
      chk("fl_first_ipc",   32'(bus_a.o_instr_pc), 8);
      chk("fl_first_instr", 32'(bus_a.o_instr), 32'h108);
`endif

      // 3: short program on instance B with pop held
      bus_b.i_pop = 1'b1;
      rst_b = 1'b0;
      #1;
      n = 0; last_pc = -1;
      for (int c = 0; c < 40; c++) begin
         if (bus_b.o_valid) begin
            chk("short_instr", 32'(bus_b.o_instr), 32'h100 + 32'(n));
            chk("short_ipc",   32'(bus_b.o_instr_pc), 32'(n));
            last_pc = int'(bus_b.o_instr_pc);
            n++;
         end
         @(negedge clk);
         #1;
      end
      chk("short_n",      32'(n), 5);
      chk("short_lastpc", 32'(last_pc), 4);
      chk("short_valid",  32'(bus_b.o_valid), 0);
      chk("short_done",   32'(bus_b.o_done), 1);
      chk("short_ren",    32'(bus_b.o_imem_ren), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
